// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the encoder FEC path.
// The convolutional encoder defaults here match the standard K=7 (171,133) code.
package encoder_fec_pkg;

    localparam int                 CONV_K  = 7;
    localparam logic [CONV_K-1:0]  CONV_G0 = 7'o171;
    localparam logic [CONV_K-1:0]  CONV_G1 = 7'o133;

    // Coded symbol ordered {c0, c1}
    typedef logic [1:0] coded_symbol_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SHIFT,
        ST_TAIL
    } conv_enc_state_e;

endpackage

// File: rtl/conv_enc_serializer_core.sv
// Rate-1/2 convolutional encoder datapath: combinational symbol from the
// current bit plus encoder memory, and the memory register with advance/hold.
module conv_enc_core
    import encoder_fec_pkg::*;
#(
    parameter int             K  = CONV_K,
    parameter logic [K-1:0]   G0 = CONV_G0,
    parameter logic [K-1:0]   G1 = CONV_G1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          u_i,
    input  logic          advance_i,
    output coded_symbol_t sym_o
);

    // mem_q[K-2] is the most recent previous bit
    logic [K-2:0] mem_q;
    logic [K-2:0] mem_d;
    logic [K-1:0] r;

    assign r     = {u_i, mem_q};
    assign sym_o = {^(r & G0), ^(r & G1)};

    // NOTE: default assignment first so every path drives mem_d; no latch.
    always_comb begin
        mem_d = mem_q;
        if (advance_i) begin
            mem_d = r[K-1:1];
        end
    end

    // NOTE: state registers use non-blocking assignments and async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/conv_enc_serializer.sv
// Pops message words from the FIFO, serializes them MSB-first through the
// convolutional encoder and closes each frame with K-1 zero tail bits.
module conv_enc_serializer
    import encoder_fec_pkg::*;
#(
    parameter int             WIDTH       = 32,
    parameter int             FRAME_WORDS = 4,
    parameter int             K           = CONV_K,
    parameter logic [K-1:0]   G0          = CONV_G0,
    parameter logic [K-1:0]   G1          = CONV_G1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_data,
    input  logic              fifo_rd_valid,
    output coded_symbol_t     enc_data,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic              enc_last,
    output logic              busy
);

    localparam int CNT_MAX = (WIDTH > K) ? WIDTH : K;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int WORD_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

    conv_enc_state_e     state_q;
    logic [WIDTH-1:0]    sr_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WORD_W-1:0]   word_cnt_q;
    logic                rd_en_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;

    logic                u;
    logic                accept;
    coded_symbol_t       sym;

    // Tail bits feed zeros; valid_q is only set in SHIFT or TAIL
    assign u      = (state_q == ST_SHIFT) ? sr_q[WIDTH-1] : 1'b0;
    assign accept = valid_q && enc_ready;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .u_i       (u),
        .advance_i (accept),
        .sym_o     (sym)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q <= ST_REQ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fifo_rd_valid) begin
                        sr_q      <= fifo_data;
                        bit_cnt_q <= '0;
                        valid_q   <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        sr_q      <= sr_q << 1;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (word_cnt_q == LAST_WORD) begin
                                word_cnt_q <= '0;
                                state_q    <= ST_TAIL;
                                last_q     <= (K == 2);
                            end else begin
                                word_cnt_q <= word_cnt_q + WORD_W'(1);
                                valid_q    <= 1'b0;
                                if (enable && !fifo_empty) begin
                                    state_q <= ST_REQ;
                                    rd_en_q <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (accept) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        // Raise last for the symbol following this one
                        last_q    <= (int'(bit_cnt_q) == K - 3);
                        if (int'(bit_cnt_q) == K - 2) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign enc_valid  = valid_q;
    assign enc_data   = valid_q ? sym : '0;
    assign enc_last   = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv_enc_serializer.sv
// Directed bench for conv_enc_serializer: one single-word-frame instance and
// one four-word-frame instance, each fed by a small behavioural FIFO.
module tb_conv_enc_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enable;
    logic enc_ready;
    logic suppress;

    logic [31:0] words [2][8];
    int          avail [2];

    logic        rd_en_w  [2];
    logic [1:0]  data_w   [2];
    logic        valid_w  [2];
    logic        last_w   [2];
    logic        busy_w   [2];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] d;
        logic       last;
    } sym_t;

    sym_t       got_q [$];
    logic [1:0] exp_q [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int FW = (g == 0) ? 1 : 4;
        logic [31:0] fdata  = '0;
        logic        fvalid = 1'b0;
        logic        fempty;
        int          rd_ptr = 0;

        // FIFO model: data valid the cycle after a read request
        always @(posedge clk) begin
            if (rd_en_w[g] && !suppress) begin
                fdata  <= words[g][rd_ptr[2:0]];
                fvalid <= 1'b1;
                rd_ptr <= rd_ptr + 1;
            end else begin
                fvalid <= 1'b0;
            end
        end
        assign fempty = (rd_ptr >= avail[g]);

        conv_enc_serializer #(
            .WIDTH       (32),
            .FRAME_WORDS (FW)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (enable),
            .fifo_empty    (fempty),
            .fifo_rd_en    (rd_en_w[g]),
            .fifo_data     (fdata),
            .fifo_rd_valid (fvalid),
            .enc_data      (data_w[g]),
            .enc_valid     (valid_w[g]),
            .enc_ready     (enc_ready),
            .enc_last      (last_w[g]),
            .busy          (busy_w[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Impulse response of (171,133) for one 0x80000000 frame, hand-derived
    task automatic set_impulse();
        exp_q.delete();
        for (int i = 0; i < 38; i++) begin
            case (i)
                0:       exp_q.push_back(2'b11);
                1:       exp_q.push_back(2'b10);
                2:       exp_q.push_back(2'b11);
                3:       exp_q.push_back(2'b11);
                4:       exp_q.push_back(2'b00);
                5:       exp_q.push_back(2'b01);
                6:       exp_q.push_back(2'b11);
                default: exp_q.push_back(2'b00);
            endcase
        end
    endtask

    // Reference encoder: h[d] is the input delayed by d bits.
    // c0 taps delays 0,1,2,3,6; c1 taps delays 0,2,3,5,6.
    task automatic build_model(input int sel, input int first, input int nwords);
        logic [6:0]  h;
        logic [31:0] w;
        exp_q.delete();
        h = '0;
        for (int n = 0; n < nwords; n++) begin
            w = words[sel][first + n];
            for (int b = 31; b >= 0; b--) begin
                h = {h[5:0], w[b]};
                exp_q.push_back({h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[6],
                                 h[0] ^ h[2] ^ h[3] ^ h[5] ^ h[6]});
            end
        end
        for (int t = 0; t < 6; t++) begin
            h = {h[5:0], 1'b0};
            exp_q.push_back({h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[6],
                             h[0] ^ h[2] ^ h[3] ^ h[5] ^ h[6]});
        end
    endtask

    // Collects accepted symbols into got_q until it holds 'total' entries or
    // the cycle budget runs out; bp drives ready with the 1,0,0,1 pattern.
    task automatic capture(input int sel, input int total, input bit bp,
                           output int stab_err, output int rd_err);
        int         cyc;
        bit         hold;
        logic [1:0] held;
        cyc      = 0;
        hold     = 1'b0;
        held     = '0;
        stab_err = 0;
        rd_err   = 0;
        enc_ready = 1'b1;
        while (got_q.size() < total && cyc < 4 * total + 60) begin
            @(negedge clk);
            if (hold && (valid_w[sel] !== 1'b1 || data_w[sel] !== held)) stab_err++;
            if (valid_w[sel] && rd_en_w[sel]) rd_err++;
            if (valid_w[sel] && enc_ready) got_q.push_back(sym_t'({data_w[sel], last_w[sel]}));
            hold = valid_w[sel] && !enc_ready;
            held = data_w[sel];
            if (got_q.size() < total) begin
                @(posedge clk);
                #1;
                cyc++;
                enc_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            end
        end
        enc_ready = 1'b1;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({rd_en_w[g], data_w[g], valid_w[g], last_w[g], busy_w[g]} !== 6'b0) begin
                errors++;
                $display("FAIL reset dut%0d: outputs %b expected 000000", g,
                         {rd_en_w[g], data_w[g], valid_w[g], last_w[g], busy_w[g]});
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy_w[0] !== 1'b0 || rd_en_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: busy %b rd_en %b expected 0 0", busy_w[0], rd_en_w[0]);
        end
    endtask

    task automatic test_pop_timing();
        avail[0] = 1;
        suppress = 1'b1;
        enable   = 1'b1;
        tick();
        checks++;
        if (rd_en_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL pop req: rd_en %b busy %b expected 1 1", rd_en_w[0], busy_w[0]);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (rd_en_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop wait: rd_en %b expected 0", rd_en_w[0]);
        end
        tick();
        checks++;
        if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop race idle: busy %b valid %b expected 0 0", busy_w[0], valid_w[0]);
        end
        tick();
        checks++;
        if (rd_en_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop hold idle: rd_en %b valid %b expected 0 0", rd_en_w[0], valid_w[0]);
        end
        suppress = 1'b0;
        enable   = 1'b1;
        tick();
        checks++;
        if (rd_en_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL pop retry: rd_en %b expected 1", rd_en_w[0]);
        end
        tick();
        checks++;
        if (rd_en_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL pop single pulse: rd_en %b expected 0", rd_en_w[0]);
        end
    endtask

    task automatic test_impulse();
        int s, r;
        avail[0] = 2;
        got_q.delete();
        set_impulse();
        capture(0, 38, 1'b0, s, r);
        checks++;
        if (got_q.size() != 38) begin
            errors++;
            $display("FAIL impulse count: got %0d expected 38", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'({exp_q[i], i == 37})) begin
                errors++;
                $display("FAIL impulse sym %0d: got %b last %b expected %b last %b",
                         i, got_q[i].d, got_q[i].last, exp_q[i], i == 37);
            end
        end
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL impulse extra pop: got %0d pulses expected 0", r);
        end
        tick();
        checks++;
        if (valid_w[0] !== 1'b0 || last_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL impulse end: valid %b last %b expected 0 0", valid_w[0], last_w[0]);
        end
    endtask

    task automatic test_backpressure();
        int s, r;
        got_q.delete();
        set_impulse();
        capture(0, 38, 1'b1, s, r);
        checks++;
        if (got_q.size() != 38) begin
            errors++;
            $display("FAIL bp count: got %0d expected 38", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'({exp_q[i], i == 37})) begin
                errors++;
                $display("FAIL bp sym %0d: got %b last %b expected %b last %b",
                         i, got_q[i].d, got_q[i].last, exp_q[i], i == 37);
            end
        end
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL bp stability: got %0d unstable cycles expected 0", s);
        end
        tick();
        tick();
        checks++;
        if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp end: valid %b busy %b expected 0 0", valid_w[0], busy_w[0]);
        end
    endtask

    task automatic test_multi_word();
        int s, r;
        build_model(1, 0, 4);
        avail[1] = 4;
        got_q.delete();
        capture(1, 134, 1'b0, s, r);
        checks++;
        if (got_q.size() != 134) begin
            errors++;
            $display("FAIL multi count: got %0d expected 134", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'({exp_q[i], i == 133})) begin
                errors++;
                $display("FAIL multi sym %0d: got %b last %b expected %b last %b",
                         i, got_q[i].d, got_q[i].last, exp_q[i], i == 133);
            end
        end
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL multi pop during symbols: got %0d expected 0", r);
        end
        tick();
        checks++;
        if (valid_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL multi end: valid %b expected 0", valid_w[1]);
        end
    endtask

    task automatic test_starvation();
        int s, r;
        build_model(1, 4, 4);
        avail[1] = 6;
        got_q.delete();
        capture(1, 64, 1'b0, s, r);
        repeat (3) tick();
        checks++;
        if (busy_w[1] !== 1'b0 || valid_w[1] !== 1'b0 || rd_en_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL starve idle: busy %b valid %b rd_en %b expected 0 0 0",
                     busy_w[1], valid_w[1], rd_en_w[1]);
        end
        avail[1] = 8;
        capture(1, 134, 1'b1, s, r);
        checks++;
        if (got_q.size() != 134) begin
            errors++;
            $display("FAIL starve count: got %0d expected 134", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'({exp_q[i], i == 133})) begin
                errors++;
                $display("FAIL starve sym %0d: got %b last %b expected %b last %b",
                         i, got_q[i].d, got_q[i].last, exp_q[i], i == 133);
            end
        end
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL starve stability: got %0d unstable cycles expected 0", s);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int s, r;
        avail[0] = 3;
        got_q.delete();
        capture(0, 10, 1'b0, s, r);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en_w[0], data_w[0], valid_w[0], last_w[0], busy_w[0]} !== 6'b0) begin
            errors++;
            $display("FAIL async reset: outputs %b expected 000000",
                     {rd_en_w[0], data_w[0], valid_w[0], last_w[0], busy_w[0]});
        end
        tick();
        rst_n    = 1'b1;
        avail[0] = 4;
        got_q.delete();
        set_impulse();
        capture(0, 38, 1'b0, s, r);
        checks++;
        if (got_q.size() != 38) begin
            errors++;
            $display("FAIL post-reset count: got %0d expected 38", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'({exp_q[i], i == 37})) begin
                errors++;
                $display("FAIL post-reset sym %0d: got %b last %b expected %b last %b",
                         i, got_q[i].d, got_q[i].last, exp_q[i], i == 37);
            end
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        enc_ready = 1'b1;
        suppress  = 1'b0;
        avail[0]  = 0;
        avail[1]  = 0;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) words[g][i] = '0;
        end
        words[0][0] = 32'h8000_0000;
        words[0][1] = 32'h8000_0000;
        words[0][2] = 32'hFFFF_FFFF;
        words[0][3] = 32'h8000_0000;
        words[1][0] = 32'hFFFF_FFFF;
        words[1][1] = 32'h0000_0000;
        words[1][2] = 32'hA5A5_A5A5;
        words[1][3] = 32'h0000_0001;
        words[1][4] = 32'h1234_5678;
        words[1][5] = 32'h9ABC_DEF0;
        words[1][6] = 32'h0F0F_0F0F;
        words[1][7] = 32'hDEAD_BEEF;
        repeat (2) tick();

        test_reset();
        test_pop_timing();
        test_impulse();
        test_backpressure();
        test_multi_word();
        test_starvation();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
